seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed scanner for a multi-digit seven-segment display. Holds a frame of 4-bit hex digits and presents one digit at a time on `x` to the downstream hex-to-seven-segment decoder, while driving a one-hot digit enable in step. New frames are double-buffered and swap only at frame boundaries, so the display never tears. An anti-ghosting guard interval blanks all digit enables at the start of every slot.

## Interface
- `DIGITS`, 4: number of digits scanned; legal 1..8.
- `DIV`, 1000: clock cycles per digit slot; legal ≥ 2.
- `GUARD`, 8: cycles at start of each slot with all enables off; legal 0..DIV-1.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  capture `data` into shadow buffer this cycle.
- `data`  in  4*DIGITS  frame; digit i is `data[4i+3:4i]`, digit 0 rightmost.
- `x`  out  4  current digit nibble, to decoder `x` input.
- `an`  out  DIGITS  one-hot digit enable, active high; all-zero during guard.
- `frame`  out  1  one-cycle pulse on last cycle of each frame.

## Operation
- State: slot counter `cnt` (0..DIV-1), digit index `idx` (0..DIGITS-1), `shadow` and `active` frame registers, `pending` flag.
- `cnt` increments every cycle; wraps DIV-1 → 0 and advances `idx`; `idx` wraps DIGITS-1 → 0.
- Frame end: cycle with `cnt`=DIV-1 and `idx`=DIGITS-1.
- `load`=1: `shadow`←`data`, `pending`←1.
- At frame end with `pending`=1: `active`←`shadow`, `pending`←0.
- `load` on the frame-end cycle: `active`←`data` directly, `pending`←0. The newest data wins.
- Back-to-back loads: only the last one before the frame end is displayed. Earlier ones are overwritten silently.
- Outputs for state (`cnt`=c, `idx`=i): `x`=`active` digit i; `an`=onehot(i) if c ≥ GUARD, else 0; `frame`=1 iff frame end.
- No input handshake: `load` is always accepted.

## Timing
- Reset values: `cnt`=0, `idx`=0, `shadow`=0, `active`=0, `pending`=0. Outputs: `x`=0, `frame`=0, `an`=0 if GUARD>0, else `an`=1.
- Outputs are registered. The first cycle after reset release shows `idx`=0, `cnt`=0.
- Slot period is DIV cycles. Frame period is DIGITS×DIV cycles.
- Latency from `load` to the new digits appearing on `x` is at most one frame plus one cycle, after the next frame end.
- `x` changes only on slot boundaries and stays stable through the whole slot, including the guard.
- `rst` mid-frame: everything returns to reset values on the next edge, and any pending load is discarded.
- DIGITS=1: `idx` stays 0 and frame end occurs every DIV cycles.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking. A digit i > 0 has its `an` bit forced to 0 when it and every higher digit of `active` are 0. Digit 0 is never blanked, so all-zero shows "0".
- Not defined: every digit is enabled in its slot regardless of value.
- `x`, `cnt`, `idx` and `frame` timing are identical in both builds.

## Structure
- Shared package `seg_pkg`:
  - nibble typedef;
  - index-width constant computed via `$clog2(DIGITS)`;
  - `onehot(idx)` function (reused by other display blocks).
- Sub-module `seg_prescaler`: the `cnt` counter. Parameter DIV; outputs `cnt` and a `wrap` strobe that advances `idx`.
- The decoder is not instantiated inside. The top level wires `x` to it.

## Test plan
Bench parameters: DIGITS=4, DIV=4, GUARD=1.
- Reset release:
  - `an`=0000, `x`=0 on the first cycle.
  - `an`=0001 at cycle 1.
  - `frame` pulses at cycles 15, 31, ….
- Load `data`=16'h1A2F at cycle 5 → `x` stays 0 until cycle 16, then runs F,2,A,1 per 4-cycle slot, with `an` 0001,0010,0100,1000 on slot cycles 1–3.
- Load 16'h1111 at cycle 3, then 16'h2222 at cycle 9 → next frame shows only 2s.
- Load 16'h3333 exactly on the frame-end cycle 15 → cycle 16 shows `x`=3.
- Assert `rst` at cycle 22 with a load pending → all outputs return to reset values, and the old frame is gone after release.
- `SEG_SCAN_LZB_EN` with `active`=16'h0050 → `an` never enables digits 2 and 3; digits 0 and 1 scan normally. `active`=0 → only digit 0 is lit, showing 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment display helpers: nibble type, index-width sizing and
// the one-hot digit-enable function used by the display blocks.
package seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int MAX_IDX_W  = $clog2(MAX_DIGITS);

  typedef logic [3:0] nibble_t;

  // Width of a digit index for a given digit count; a lone digit still needs one bit.
  function automatic int idx_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Slot counter for the display scanner: counts 0..DIV-1 and flags the last
// cycle of each slot with wrap.
module seg_prescaler #(
  parameter int DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [$clog2(DIV)-1:0]  cnt,
  output logic                    wrap
);

  localparam int CW = $clog2(DIV);

  assign wrap = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || wrap) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with double-buffered frames and a guard
// blanking interval. Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int GUARD  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  output logic [3:0]            x,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int IW = idx_w(DIGITS);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0]          cnt, cnt_nx;
  logic                   wrap, fend, fend_nx;
  logic [IW-1:0]          idx, idx_nx;
  nibble_t [DIGITS-1:0]   shadow, active, active_nx;
  logic                   pending, pending_nx;
  logic [DIGITS-1:0]      lit, an_nx;

  seg_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Outputs are registered from next-state values so they line up with cnt/idx.
  always_comb begin
    fend       = wrap && (idx == IW'(DIGITS - 1));
    cnt_nx     = wrap ? '0 : cnt + 1'b1;
    idx_nx     = idx;
    if (wrap) idx_nx = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    active_nx  = active;
    pending_nx = pending;
    if (load) pending_nx = 1'b1;
    if (fend) begin
      pending_nx = 1'b0;
      if (load)         active_nx = data;
      else if (pending) active_nx = shadow;
    end
    fend_nx = (cnt_nx == CW'(DIV - 1)) && (idx_nx == IW'(DIGITS - 1));
    an_nx   = (cnt_nx >= CW'(GUARD)) ? (DIGITS'(onehot(MAX_IDX_W'(idx_nx))) & lit) : '0;
  end

`ifdef SEG_SCAN_LZB_EN
  // Scan from the top digit down; a digit stays lit once any digit at or above it is nonzero.
  always_comb begin
    logic seen;
    lit  = '1;
    seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen   = seen | (active_nx[i] != 4'h0);
      lit[i] = seen;
    end
  end
`else
  assign lit = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      x       <= '0;
      an      <= (GUARD > 0) ? '0 : DIGITS'(1);
      frame   <= 1'b0;
    end else begin
      idx     <= idx_nx;
      if (load) shadow <= data;
      active  <= active_nx;
      pending <= pending_nx;
      x       <= active_nx[idx_nx];
      an      <= an_nx;
      frame   <= fend_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed frame scenarios plus randomized
// loads/resets against a cycle-count based reference model.
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int GUARD  = 1;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  x;
  logic [3:0]  an;
  logic        frame;

  int checks   = 0;
  int failures = 0;

  // Reference state: cycles since reset release plus the frame buffers.
  int          m_t;
  logic [15:0] m_active, m_shadow;
  logic        m_pending;

  seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (data),
    .x     (x),
    .an    (an),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, m_t, got, exp);
    end
  endtask

  task automatic tick(input logic ld, input logic [15:0] d, input logic r);
    int c, i;
    logic [3:0] ex, ea;
    logic ef;
    load = ld;
    data = d;
    rst  = r;
    @(negedge clk);
    c  = m_t % DIV;
    i  = (m_t / DIV) % DIGITS;
    ex = 4'(m_active >> (4 * i));
    ea = '0;
    if (c >= GUARD) begin
      ea = 4'(1 << i);
`ifdef SEG_SCAN_LZB_EN
      if (i > 0 && (m_active >> (4 * i)) == 16'h0) ea = '0;
`endif
    end
    ef = (m_t % FRAME) == FRAME - 1;
    chk("x", 32'(x), 32'(ex));
    chk("an", 32'(an), 32'(ea));
    chk("frame", 32'(frame), 32'(ef));
    @(posedge clk);
    if (r) begin
      m_t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
    end else begin
      if (ef) begin
        if (ld)             m_active = d;
        else if (m_pending) m_active = m_shadow;
        m_pending = 1'b0;
      end else if (ld) begin
        m_pending = 1'b1;
      end
      if (ld) m_shadow = d;
      m_t++;
    end
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 16'h0, 1'b1);
  endtask

  task automatic run_to(input int n);
    while (m_t < n) tick(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    logic        ld, r;
    rst = 1'b1; load = 1'b0; data = '0;
    m_t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
    @(posedge clk);
    #1;

    // Reset release, first load and the scan order.
    do_reset();
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_x", 32'(x), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    run_to(1);  chk("an_c1", 32'(an), 32'h1);
    run_to(5);  tick(1'b1, 16'h1A2F, 1'b0);
    run_to(15); chk("frame_c15", 32'(frame), 32'h1); chk("x_c15", 32'(x), 32'h0);
    run_to(16); chk("x_c16", 32'(x), 32'hF); chk("an_c16", 32'(an), 32'h0);
    run_to(21); chk("x_c21", 32'(x), 32'h2); chk("an_c21", 32'(an), 32'h2);
    run_to(25); chk("x_c25", 32'(x), 32'hA); chk("an_c25", 32'(an), 32'h4);
    run_to(29); chk("x_c29", 32'(x), 32'h1); chk("an_c29", 32'(an), 32'h8);
    run_to(31); chk("frame_c31", 32'(frame), 32'h1);

    // Back-to-back loads: last one wins.
    do_reset();
    run_to(3);  tick(1'b1, 16'h1111, 1'b0);
    run_to(9);  tick(1'b1, 16'h2222, 1'b0);
    run_to(16); chk("b2b_c16", 32'(x), 32'h2);
    run_to(28); chk("b2b_c28", 32'(x), 32'h2);

    // Load on the frame-end cycle goes straight to the display.
    do_reset();
    run_to(15); tick(1'b1, 16'h3333, 1'b0);
    chk("fe_load_c16", 32'(x), 32'h3);

    // Mid-frame reset discards both the shown and the pending frame.
    do_reset();
    run_to(2);  tick(1'b1, 16'h4444, 1'b0);
    run_to(16); chk("pre_rst_x", 32'(x), 32'h4);
    run_to(20); tick(1'b1, 16'h5555, 1'b0);
    run_to(22); tick(1'b0, 16'h0, 1'b1);
    chk("mid_rst_x", 32'(x), 32'h0);
    chk("mid_rst_an", 32'(an), 32'h0);
    chk("mid_rst_frame", 32'(frame), 32'h0);
    run_to(17); chk("post_rst_x", 32'(x), 32'h0);

    // Leading zeros: 0050 then all-zero.
    do_reset();
    run_to(3);  tick(1'b1, 16'h0050, 1'b0);
    run_to(21); chk("lz_an_d1", 32'(an), 32'h2);
    run_to(25);
`ifdef SEG_SCAN_LZB_EN
    chk("lz_an_d2", 32'(an), 32'h0);
`else
    chk("lz_an_d2", 32'(an), 32'h4);
`endif
    tick(1'b1, 16'h0000, 1'b0);
    run_to(33); chk("zero_an_d0", 32'(an), 32'h1); chk("zero_x_d0", 32'(x), 32'h0);
    run_to(37);
`ifdef SEG_SCAN_LZB_EN
    chk("zero_an_d1", 32'(an), 32'h0);
`else
    chk("zero_an_d1", 32'(an), 32'h2);
`endif

    // Randomized loads with zero-heavy nibbles and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < DIGITS; k++)
        d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      ld = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 299) == 0);
      tick(ld, d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
